// File: rtl/tx_lpkt_seq.sv
// tx_lpkt_seq: serialises one long packet per descriptor onto a byte stream.
// Each packet is four header bytes ({vc,dt}, wc[7:0], wc[15:8], ecc), then wc
// payload bytes, then a CRC-16 (poly 0x1021 reflected, init 0xFFFF) sent LSB first.
// The CRC covers the payload only.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   pkt_valid/pkt_ready      descriptor handshake (pkt_vc, pkt_dt, pkt_wc, pkt_ecc)
//   pld_valid/pld_ready      payload byte stream in (pld_data)
//   tx_valid/tx_ready        packet byte stream out (tx_data, tx_last on the final byte)
//   busy                     high while a packet is in progress
//   crc_out                  checksum of the last completed packet
module tx_lpkt_seq #(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [1:0]  pkt_vc,
    input  logic [5:0]  pkt_dt,
    input  logic [15:0] pkt_wc,
    input  logic [7:0]  pkt_ecc,
    input  logic        pld_valid,
    input  logic [7:0]  pld_data,
    output logic        pld_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] crc_out
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StHdr  = 3'd1;
    localparam logic [2:0] StPld  = 3'd2;
    localparam logic [2:0] StCrc  = 3'd3;
    localparam logic [2:0] StGap  = 3'd4;

    localparam int unsigned GapLoad = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    logic [2:0]  state_q, state_d;
    logic [7:0]  vcdt_q, vcdt_d;
    logic [15:0] wc_q, wc_d;
    logic [7:0]  ecc_q, ecc_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic        crc_hi_q, crc_hi_d;
    logic [15:0] crc_out_q, crc_out_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_last_q, tx_last_d;

    logic can_load;
    logic tx_xfer;

    // Reflected CRC-16, one byte per call, data bits taken LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // The output register can take a new byte when empty or being drained now.
    assign can_load  = !tx_valid_q || tx_ready;
    assign tx_xfer   = tx_valid_q && tx_ready;

    assign pkt_ready = (state_q == StIdle) && !rst;
    assign pld_ready = (state_q == StPld) && (rem_q != 16'd0) && can_load && !rst;
    assign busy      = (state_q != StIdle);
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign tx_last   = tx_last_q;
    assign crc_out   = crc_out_q;

    always_comb begin
        state_d    = state_q;
        vcdt_d     = vcdt_q;
        wc_d       = wc_q;
        ecc_d      = ecc_q;
        hdr_idx_d  = hdr_idx_q;
        rem_d      = rem_q;
        crc_d      = crc_q;
        crc_hi_d   = crc_hi_q;
        crc_out_d  = crc_out_q;
        gap_cnt_d  = gap_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;

        if (tx_xfer) begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            if (tx_last_q) begin
                crc_out_d = crc_q;
            end
        end

        case (state_q)
            StIdle: begin
                if (pkt_valid && pkt_ready) begin
                    vcdt_d     = {pkt_vc, pkt_dt};
                    wc_d       = pkt_wc;
                    ecc_d      = pkt_ecc;
                    rem_d      = pkt_wc;
                    crc_d      = 16'hFFFF;
                    crc_hi_d   = 1'b0;
                    // First header byte goes straight into the output register.
                    tx_valid_d = 1'b1;
                    tx_data_d  = {pkt_vc, pkt_dt};
                    tx_last_d  = 1'b0;
                    hdr_idx_d  = 2'd1;
                    state_d    = StHdr;
                end
            end
            StHdr: begin
                if (can_load) begin
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    case (hdr_idx_q)
                        2'd1:    tx_data_d = wc_q[7:0];
                        2'd2:    tx_data_d = wc_q[15:8];
                        default: tx_data_d = ecc_q;
                    endcase
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        state_d = (wc_q != 16'd0) ? StPld : StCrc;
                    end
                end
            end
            StPld: begin
                if (pld_valid && pld_ready) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = pld_data;
                    tx_last_d  = 1'b0;
                    rem_d      = rem_q - 16'd1;
                    crc_d      = crc16_byte(crc_q, pld_data);
                    if (rem_q == 16'd1) begin
                        state_d = StCrc;
                    end
                end
            end
            StCrc: begin
                if (tx_last_q) begin
                    // High byte already loaded; wait for it to leave.
                    if (tx_xfer) begin
                        gap_cnt_d = 16'(GapLoad);
                        state_d   = (IDLE_GAP == 0) ? StIdle : StGap;
                    end
                end else if (can_load) begin
                    tx_valid_d = 1'b1;
                    if (!crc_hi_q) begin
                        tx_data_d = crc_q[7:0];
                        crc_hi_d  = 1'b1;
                    end else begin
                        tx_data_d = crc_q[15:8];
                        tx_last_d = 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            vcdt_q     <= 8'h00;
            wc_q       <= 16'h0000;
            ecc_q      <= 8'h00;
            hdr_idx_q  <= 2'd0;
            rem_q      <= 16'h0000;
            crc_q      <= 16'hFFFF;
            crc_hi_q   <= 1'b0;
            crc_out_q  <= 16'h0000;
            gap_cnt_q  <= 16'h0000;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vcdt_q     <= vcdt_d;
            wc_q       <= wc_d;
            ecc_q      <= ecc_d;
            hdr_idx_q  <= hdr_idx_d;
            rem_q      <= rem_d;
            crc_q      <= crc_d;
            crc_hi_q   <= crc_hi_d;
            crc_out_q  <= crc_out_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
        end
    end

endmodule

// File: doc/tx_lpkt_seq.md
TX_LPKT_SEQ -- requirements
Module: tx_lpkt_seq

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 0, giving the minimum idle cycles between the last byte of one packet and acceptance of the next descriptor.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have pkt_valid (input, 1) and pkt_ready (output, 1): the descriptor handshake.
REQ-005 SHALL have pkt_vc (input, 2), pkt_dt (input, 6), pkt_wc (input, 16) and pkt_ecc (input, 8): virtual channel, data type, payload byte count and header ECC.
REQ-006 SHALL have pld_valid (input, 1), pld_data (input, 8) and pld_ready (output, 1): the payload byte stream.
REQ-007 SHALL have tx_valid (output, 1), tx_data (output, 8), tx_last (output, 1) and tx_ready (input, 1): the packet byte stream.
REQ-008 SHALL have busy (output, 1) and crc_out (output, 16): busy flags a packet in progress; crc_out holds the last completed checksum.

Function
REQ-009 SHALL transfer on any interface only when valid and ready are both high in the same cycle.
REQ-010 SHALL implement states IDLE, HDR, PLD, CRC and GAP.
REQ-011 SHALL drive pkt_ready high only in IDLE.
REQ-012 SHALL, on descriptor acceptance in IDLE, latch all descriptor fields, set the CRC to 0xFFFF and enter HDR.
REQ-013 SHALL emit four header bytes in HDR, in this order: {vc,dt}, wc[7:0], wc[15:8], ecc.
REQ-014 SHALL, after the header, enter PLD if the latched wc is non-zero, otherwise CRC.
REQ-015 SHALL register tx_valid and tx_data; the first header byte appears on tx_valid in the cycle after descriptor acceptance.
REQ-016 SHALL hold tx_data and tx_last stable while tx_valid=1 and tx_ready=0.
REQ-017 SHALL sustain one byte per cycle when tx_ready stays high; no bubbles at header/payload/CRC boundaries.
REQ-018 SHALL assert pld_ready only when all three hold: state is PLD, payload bytes remain, and the output register is empty or being drained (!tx_valid || tx_ready).
REQ-019 SHALL, on each accepted payload byte, forward it to tx_data, decrement the remaining count and update the CRC.
REQ-020 SHALL, on the last accepted payload byte, enter CRC.
REQ-021 SHALL compute the CRC as CRC-16 polynomial x^16+x^12+x^5+1, init 0xFFFF, data bits LSB-first (reflected), no final XOR, one byte per cycle.
REQ-022 SHALL emit crc[7:0] then crc[15:8] in CRC, and assert tx_last only with crc[15:8].
REQ-023 SHALL emit 0xFF, 0xFF as the checksum bytes for wc=0.
REQ-024 SHALL load crc_out when the CRC high byte is transferred.
REQ-025 SHALL, after the tx_last transfer, enter GAP for IDLE_GAP cycles and then IDLE; with IDLE_GAP=0 it goes directly to IDLE.
REQ-026 SHALL drive busy high in every state except IDLE.
REQ-027 SHALL ignore pld_valid outside PLD; such bytes are not consumed.
REQ-028 SHALL ignore pkt_valid while not in IDLE.
REQ-029 SHALL treat wc=0xFFFF as legal: 65535 payload bytes, with the counter not wrapping.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE from any state and abandon any partial packet without asserting tx_last.
REQ-031 SHALL set these reset values: tx_valid=0, tx_data=0x00, tx_last=0, pld_ready=0, busy=0, crc_out=0x0000 and internal CRC=0xFFFF.
REQ-032 SHALL hold pkt_ready at 0 during reset and set it to 1 in the first cycle after rst deasserts.

Verification
REQ-033 SHALL cover: vc=0, dt=0x39, wc=9, ecc=0x2A, payload 0x31..0x39, tx_ready=1 -> tx 39 09 00 2A 31 32 33 34 35 36 37 38 39 91 6F in 15 consecutive cycles; tx_last on 0x6F; crc_out=0x6F91.
REQ-034 SHALL cover: wc=0, dt=0x29, ecc=0x11 -> tx 29 00 00 11 FF FF; pld_ready never asserted; crc_out=0xFFFF.
REQ-035 SHALL cover: scenario REQ-033 with tx_ready toggled pseudo-randomly -> identical byte sequence, no byte dropped or duplicated, tx_data stable while stalled.
REQ-036 SHALL cover: scenario REQ-033 with pld_valid low on alternate cycles -> identical output bytes and CRC 0x6F91; tx_valid gaps allowed only in PLD.
REQ-037 SHALL cover: rst pulsed after the 5th payload byte -> next cycle tx_valid=0, busy=0, pkt_ready=1, no tx_last; a following packet per REQ-034 is emitted correctly.
REQ-038 SHALL cover: IDLE_GAP=2 with pkt_valid held high for two packets -> pkt_ready low for exactly 2 cycles after the first tx_last transfer, then the second header follows.
